// File: rtl/data_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single data bus controller.
// Misaligned or illegal requests are rejected locally with an error pulse.
// A stuck slave is cut off after TIMEOUT wait cycles.
module data_bus_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_done,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_done,
    output logic        m1_err,
    output logic        s_req,
    output logic        s_we,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_ack
);

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

    state_t      state, state_nxt;
    logic        last, last_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        s_req_nxt, s_we_nxt;
    logic [1:0]  s_size_nxt;
    logic [31:0] s_addr_nxt, s_wdata_nxt;
    logic [1:0]  done_nxt, err_nxt;
    logic [31:0] rdata0_nxt, rdata1_nxt;

    // A requester whose done pulse is showing this cycle is still holding a
    // stale request, so it is not eligible until the pulse is gone.
    logic        elig0, elig1, sel, owner;
    logic        sel_we;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr, sel_wdata;
    logic        sel_bad;

    assign elig0     = m0_req & ~m0_done;
    assign elig1     = m1_req & ~m1_done;
    // On contention the requester not served last wins.
    assign sel       = (elig0 & elig1) ? ~last : elig1;
    assign sel_we    = sel ? m1_we    : m0_we;
    assign sel_size  = sel ? m1_size  : m0_size;
    assign sel_addr  = sel ? m1_addr  : m0_addr;
    assign sel_wdata = sel ? m1_wdata : m0_wdata;
    assign sel_bad   = (sel_size == 2'b11) ||
                       (sel_size == 2'b01 && sel_addr[0]) ||
                       (sel_size == 2'b10 && sel_addr[1:0] != 2'b00);
    assign owner     = (state == BUSY1);

    // Next-state, grant and completion decisions.
    always_comb begin
        state_nxt   = state;
        last_nxt    = last;
        cnt_nxt     = cnt;
        s_req_nxt   = s_req;
        s_we_nxt    = s_we;
        s_size_nxt  = s_size;
        s_addr_nxt  = s_addr;
        s_wdata_nxt = s_wdata;
        done_nxt    = 2'b00;
        err_nxt     = 2'b00;
        rdata0_nxt  = 32'h0;
        rdata1_nxt  = 32'h0;
        case (state)
            IDLE: begin
                if (elig0 | elig1) begin
                    if (sel_bad) begin
                        done_nxt[sel] = 1'b1;
                        err_nxt[sel]  = 1'b1;
                        last_nxt      = sel;
                    end else begin
                        s_req_nxt   = 1'b1;
                        s_we_nxt    = sel_we;
                        s_size_nxt  = sel_size;
                        s_addr_nxt  = sel_addr;
                        s_wdata_nxt = sel_wdata;
                        cnt_nxt     = 8'd0;
                        state_nxt   = sel ? BUSY1 : BUSY0;
                    end
                end
            end
            BUSY0, BUSY1: begin
                if (s_ack) begin
                    // Ack beats the timeout on the same edge.
                    done_nxt[owner] = 1'b1;
                    if (!s_we) begin
                        if (owner) rdata1_nxt = s_rdata;
                        else       rdata0_nxt = s_rdata;
                    end
                    s_req_nxt = 1'b0;
                    last_nxt  = owner;
                    state_nxt = IDLE;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    done_nxt[owner] = 1'b1;
                    err_nxt[owner]  = 1'b1;
                    s_req_nxt = 1'b0;
                    last_nxt  = owner;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any transaction at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            cnt      <= 8'd0;
            s_req    <= 1'b0;
            s_we     <= 1'b0;
            s_size   <= 2'b00;
            s_addr   <= 32'h0;
            s_wdata  <= 32'h0;
            m0_done  <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= 32'h0;
            m1_done  <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= 32'h0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            cnt      <= cnt_nxt;
            s_req    <= s_req_nxt;
            s_we     <= s_we_nxt;
            s_size   <= s_size_nxt;
            s_addr   <= s_addr_nxt;
            s_wdata  <= s_wdata_nxt;
            m0_done  <= done_nxt[0];
            m0_err   <= err_nxt[0];
            m0_rdata <= rdata0_nxt;
            m1_done  <= done_nxt[1];
            m1_err   <= err_nxt[1];
            m1_rdata <= rdata1_nxt;
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a transaction-level model.
module tb_data_bus_arbiter;

    localparam int TMO = 4;

    logic        clk, rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_done, m0_err, m1_done, m1_err;
    logic        s_req, s_we, s_ack;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata, s_rdata;

    int vectors = 0;
    int misc    = 0;

    data_bus_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
        .s_req(s_req), .s_we(s_we), .s_size(s_size), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ack(s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int r0, r1, we0, we1, sz0, sz1;
        logic [31:0] a0, a1;
        int ack;
        logic [31:0] rd;
        int e_sreq;
        logic [31:0] e_addr;
        int e_d0, e_e0, e_d1, e_e1;
        logic [31:0] e_rd0, e_rd1;
    } vec_t;

    vec_t tbl[16];

    // model state
    int          owner, waited, last;
    logic        x_sreq, x_we;
    logic [1:0]  x_size;
    logic [31:0] x_addr, x_wdata;
    logic [1:0]  x_done, x_err;
    logic [31:0] x_rd0, x_rd1;
    bit          pend0, pend1;

    task automatic chk1(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        m0_req = 0; m0_we = 0; m0_size = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0;
        s_ack = 0; s_rdata = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        clr_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    function automatic bit aligned(input logic [1:0] size, input logic [31:0] addr);
        case (size)
            2'd0:    return 1'b1;
            2'd1:    return (addr % 2) == 0;
            2'd2:    return (addr % 4) == 0;
            default: return 1'b0;
        endcase
    endfunction

    // Predict the outputs after the coming edge from the inputs now applied.
    task automatic model_step();
        logic [1:0] nd, ne;
        logic [31:0] r0, r1;
        bit c0, c1;
        int w;
        nd = 0; ne = 0; r0 = 0; r1 = 0;
        if (owner < 0) begin
            c0 = m0_req && !x_done[0];
            c1 = m1_req && !x_done[1];
            if (c0 || c1) begin
                if (c0 && c1) w = (last == 0) ? 1 : 0;
                else          w = c1 ? 1 : 0;
                if (!aligned(w ? m1_size : m0_size, w ? m1_addr : m0_addr)) begin
                    nd[w] = 1; ne[w] = 1; last = w;
                end else begin
                    owner = w; waited = 0; x_sreq = 1;
                    x_we    = w ? m1_we    : m0_we;
                    x_size  = w ? m1_size  : m0_size;
                    x_addr  = w ? m1_addr  : m0_addr;
                    x_wdata = w ? m1_wdata : m0_wdata;
                end
            end
        end else if (s_ack) begin
            nd[owner] = 1;
            if (owner == 1) r1 = x_we ? 32'h0 : s_rdata;
            else            r0 = x_we ? 32'h0 : s_rdata;
            x_sreq = 0; last = owner; owner = -1;
        end else if (waited + 1 == TMO) begin
            nd[owner] = 1; ne[owner] = 1;
            x_sreq = 0; last = owner; owner = -1;
        end else begin
            waited++;
        end
        x_done = nd; x_err = ne; x_rd0 = r0; x_rd1 = r1;
    endtask

    task automatic drive_masters();
        if (x_done[0]) pend0 = 0;
        if (!pend0 && $urandom_range(0, 3) == 0) begin
            pend0 = 1; m0_req = 1; m0_we = 1'($urandom);
            m0_size = 2'($urandom_range(0, 3));
            m0_addr = $urandom & 32'hFFF; m0_wdata = $urandom;
        end else if (!pend0) m0_req = 0;
        else if (owner == 0 && $urandom_range(0, 19) == 0) m0_req = 0;
        if (x_done[1]) pend1 = 0;
        if (!pend1 && $urandom_range(0, 3) == 0) begin
            pend1 = 1; m1_req = 1; m1_we = 1'($urandom);
            m1_size = 2'($urandom_range(0, 3));
            m1_addr = $urandom & 32'hFFF; m1_wdata = $urandom;
        end else if (!pend1) m1_req = 0;
        else if (owner == 1 && $urandom_range(0, 19) == 0) m1_req = 0;
        s_ack   = ($urandom_range(0, 2) == 0);
        s_rdata = $urandom;
    endtask

    initial begin
        rst = 0;
        clr_inputs();

        // ---------------- reset state ----------------
        do_reset();
        chk1("rst_s_req", s_req, 1'b0);
        chk1("rst_m0_done", m0_done, 1'b0);
        chk1("rst_m1_done", m1_done, 1'b0);
        chk1("rst_m0_err", m0_err, 1'b0);
        chk32("rst_s_addr", s_addr, 32'h0);
        chk32("rst_m1_rdata", m1_rdata, 32'h0);

        // ---------------- vector table ----------------
        tbl[0]  = '{0,0,0,0,0,0, 32'h0,   32'h0,   1, 32'hAAAA5555, 0, 32'h0,   0,0,0,0, 32'h0, 32'h0};
        tbl[1]  = '{0,1,0,1,0,1, 32'h0,   32'h203, 0, 32'h0,        0, 32'h0,   0,0,1,1, 32'h0, 32'h0};
        tbl[2]  = '{0,1,0,1,0,1, 32'h0,   32'h203, 0, 32'h0,        0, 32'h0,   0,0,0,0, 32'h0, 32'h0};
        tbl[3]  = '{1,0,0,0,2,0, 32'h8,   32'h0,   0, 32'h0,        1, 32'h8,   0,0,0,0, 32'h0, 32'h0};
        tbl[4]  = '{1,0,0,0,2,0, 32'h8,   32'h0,   1, 32'h12345678, 0, 32'h0,   1,0,0,0, 32'h12345678, 32'h0};
        tbl[5]  = '{0,0,0,0,0,0, 32'h0,   32'h0,   0, 32'h0,        0, 32'h0,   0,0,0,0, 32'h0, 32'h0};
        tbl[6]  = '{1,0,0,0,3,0, 32'h10,  32'h0,   0, 32'h0,        0, 32'h0,   1,1,0,0, 32'h0, 32'h0};
        tbl[7]  = '{0,0,0,0,0,0, 32'h0,   32'h0,   0, 32'h0,        0, 32'h0,   0,0,0,0, 32'h0, 32'h0};
        tbl[8]  = '{0,1,0,1,0,1, 32'h0,   32'h202, 0, 32'h0,        1, 32'h202, 0,0,0,0, 32'h0, 32'h0};
        tbl[9]  = '{0,1,0,1,0,1, 32'h0,   32'h202, 1, 32'hFFFF0000, 0, 32'h0,   0,0,1,0, 32'h0, 32'h0};
        tbl[10] = '{0,0,0,0,0,0, 32'h0,   32'h0,   1, 32'h99,       0, 32'h0,   0,0,0,0, 32'h0, 32'h0};
        tbl[11] = '{1,1,0,0,0,0, 32'h3,   32'h5,   0, 32'h0,        1, 32'h3,   0,0,0,0, 32'h0, 32'h0};
        tbl[12] = '{1,1,0,0,0,0, 32'h3,   32'h5,   1, 32'h00C0FFEE, 0, 32'h0,   1,0,0,0, 32'h00C0FFEE, 32'h0};
        tbl[13] = '{0,1,0,0,0,0, 32'h3,   32'h5,   0, 32'h0,        1, 32'h5,   0,0,0,0, 32'h0, 32'h0};
        tbl[14] = '{0,1,0,0,0,0, 32'h3,   32'h5,   1, 32'h77,       0, 32'h0,   0,0,1,0, 32'h0, 32'h77};
        tbl[15] = '{0,0,0,0,0,0, 32'h0,   32'h0,   0, 32'h0,        0, 32'h0,   0,0,0,0, 32'h0, 32'h0};
        for (int i = 0; i < 16; i++) begin
            m0_req = (tbl[i].r0 != 0); m1_req = (tbl[i].r1 != 0);
            m0_we  = (tbl[i].we0 != 0); m1_we = (tbl[i].we1 != 0);
            m0_size = 2'(tbl[i].sz0); m1_size = 2'(tbl[i].sz1);
            m0_addr = tbl[i].a0; m1_addr = tbl[i].a1;
            s_ack = (tbl[i].ack != 0); s_rdata = tbl[i].rd;
            step();
            chk1($sformatf("tbl%0d_s_req", i), s_req, tbl[i].e_sreq != 0);
            chk1($sformatf("tbl%0d_m0_done", i), m0_done, tbl[i].e_d0 != 0);
            chk1($sformatf("tbl%0d_m0_err", i), m0_err, tbl[i].e_e0 != 0);
            chk1($sformatf("tbl%0d_m1_done", i), m1_done, tbl[i].e_d1 != 0);
            chk1($sformatf("tbl%0d_m1_err", i), m1_err, tbl[i].e_e1 != 0);
            if (tbl[i].e_sreq != 0) chk32($sformatf("tbl%0d_s_addr", i), s_addr, tbl[i].e_addr);
            if (tbl[i].e_d0 != 0 && tbl[i].e_e0 == 0) chk32($sformatf("tbl%0d_m0_rdata", i), m0_rdata, tbl[i].e_rd0);
            if (tbl[i].e_d1 != 0 && tbl[i].e_e1 == 0) chk32($sformatf("tbl%0d_m1_rdata", i), m1_rdata, tbl[i].e_rd1);
        end

        // ---------------- load word, ack after wait cycles ----------------
        do_reset();
        m0_req = 1; m0_we = 0; m0_size = 2'b10; m0_addr = 32'h100;
        step();
        chk1("ld_s_req", s_req, 1'b1);
        chk32("ld_s_addr", s_addr, 32'h100);
        chk1("ld_s_we", s_we, 1'b0);
        chk32("ld_s_size", 32'(s_size), 32'd2);
        repeat (2) begin
            step();
            chk1("ld_hold_s_req", s_req, 1'b1);
            chk1("ld_hold_done", m0_done, 1'b0);
        end
        s_ack = 1; s_rdata = 32'hDEADBEEF;
        step();
        s_ack = 0; m0_req = 0;
        chk1("ld_m0_done", m0_done, 1'b1);
        chk1("ld_m0_err", m0_err, 1'b0);
        chk32("ld_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk1("ld_m1_done", m1_done, 1'b0);
        chk1("ld_s_req_drop", s_req, 1'b0);
        step();
        chk1("ld_pulse_end", m0_done, 1'b0);

        // ---------------- ack on the timeout edge wins ----------------
        m0_req = 1; m0_addr = 32'h104;
        step();
        chk1("race_s_req", s_req, 1'b1);
        repeat (TMO - 1) step();
        chk1("race_pre_done", m0_done, 1'b0);
        s_ack = 1; s_rdata = 32'h5A5A1234;
        step();
        s_ack = 0; m0_req = 0;
        chk1("race_done", m0_done, 1'b1);
        chk1("race_err", m0_err, 1'b0);
        chk32("race_rdata", m0_rdata, 32'h5A5A1234);
        step();

        // ---------------- timeout with no ack ----------------
        m0_req = 1; m0_addr = 32'h108; s_rdata = 32'hFFFFFFFF;
        step();
        for (int k = 0; k < TMO - 1; k++) begin
            step();
            chk1("tmo_wait_s_req", s_req, 1'b1);
            chk1("tmo_wait_done", m0_done, 1'b0);
        end
        step();
        m0_req = 0;
        chk1("tmo_done", m0_done, 1'b1);
        chk1("tmo_err", m0_err, 1'b1);
        chk32("tmo_rdata", m0_rdata, 32'h0);
        chk1("tmo_s_req", s_req, 1'b0);

        // ---------------- both held: alternate grants ----------------
        do_reset();
        m0_req = 1; m0_size = 2'b10; m0_addr = 32'h1000;
        m1_req = 1; m1_size = 2'b10; m1_addr = 32'h2000;
        for (int k = 0; k < 4; k++) begin
            int n;
            n = 0;
            while (!s_req && n < 5) begin step(); n++; end
            chk1($sformatf("rr%0d_grant", k), s_req, 1'b1);
            chk32($sformatf("rr%0d_addr", k), s_addr, (k % 2 == 0) ? 32'h1000 : 32'h2000);
            s_ack = 1; s_rdata = 32'(k);
            step();
            s_ack = 0;
            chk1($sformatf("rr%0d_m0_done", k), m0_done, k % 2 == 0);
            chk1($sformatf("rr%0d_m1_done", k), m1_done, k % 2 == 1);
        end

        // ---------------- reset mid-transaction ----------------
        do_reset();
        m1_req = 1; m1_size = 2'b10; m1_addr = 32'h300;
        step();
        chk1("mid_busy1", s_req, 1'b1);
        #2 rst = 0;
        #1;
        chk1("mid_rst_s_req", s_req, 1'b0);
        chk32("mid_rst_s_addr", s_addr, 32'h0);
        chk1("mid_rst_m1_done", m1_done, 1'b0);
        m0_req = 1; m0_size = 2'b10; m0_addr = 32'h400;
        @(negedge clk);
        rst = 1;
        step();
        chk1("mid_regrant", s_req, 1'b1);
        chk32("mid_regrant_addr", s_addr, 32'h400);
        chk1("mid_no_done", m1_done, 1'b0);

        // ---------------- random traffic vs model ----------------
        do_reset();
        owner = -1; waited = 0; last = 1;
        x_sreq = 0; x_we = 0; x_size = 0; x_addr = 0; x_wdata = 0;
        x_done = 0; x_err = 0; x_rd0 = 0; x_rd1 = 0;
        pend0 = 0; pend1 = 0;
        for (int c = 0; c < 800; c++) begin
            drive_masters();
            model_step();
            step();
            chk1("rnd_s_req", s_req, x_sreq);
            chk1("rnd_m0_done", m0_done, x_done[0]);
            chk1("rnd_m0_err", m0_err, x_err[0]);
            chk1("rnd_m1_done", m1_done, x_done[1]);
            chk1("rnd_m1_err", m1_err, x_err[1]);
            if (x_done[0] && !x_err[0]) chk32("rnd_m0_rdata", m0_rdata, x_rd0);
            if (x_done[1] && !x_err[1]) chk32("rnd_m1_rdata", m1_rdata, x_rd1);
            if (x_sreq) begin
                chk32("rnd_s_addr", s_addr, x_addr);
                chk32("rnd_s_wdata", s_wdata, x_wdata);
                chk1("rnd_s_we", s_we, x_we);
                chk32("rnd_s_size", 32'(s_size), 32'(x_size));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
